// File: rtl/fetch_unit_pkg.sv
// Shared control definitions for the fetch stage and the control decoder.
//   - PC-select encodings carried on selpctype
//   - fetch state enumeration
//   - instruction field positions (op, fn, branch immediate, jump target)
package fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc4       in  32  address of the held instruction plus 4
//   instr     in  32  held instruction word
//   selpctype in  2   PC-select code (PC_SEQ/PC_BR/PC_JMP/PC_REG)
//   redirect  in  1   apply selpctype; otherwise sequential
//   regaddr   in  32  register target
//   nextpc    out 32  next fetch address (always word-aligned)
//   misalign  out 1   register target had non-zero low bits
module pc_next_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] instr,
  input  logic [1:0]  selpctype,
  input  logic        redirect,
  input  logic [31:0] regaddr,
  output logic [31:0] nextpc,
  output logic        misalign
);

  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_reg_target;
  logic        w_unused_op;

  // Sign-extended word offset; the sum wraps modulo 2^32.
  assign w_br_target  = pc4 + {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  assign w_jmp_target = {pc4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};
  assign w_reg_target = {regaddr[31:2], 2'b00};
  assign w_unused_op  = ^instr[OP_MSB:OP_LSB];

  always_comb begin
    nextpc   = pc4;
    misalign = 1'b0;
    if (redirect) begin
      case (selpctype)
        PC_BR:   nextpc = w_br_target;
        PC_JMP:  nextpc = w_jmp_target;
        PC_REG: begin
          nextpc   = w_reg_target;
          misalign = (regaddr[1:0] != 2'b00);
        end
        default: nextpc = pc4;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/ack handshake and presents it to decode until consumed.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   imemaddr/imemreq      fetch address and request (held until ack)
//   imemack/imemdata      memory acknowledge and instruction word
//   instr/op/fn/pc4/valid held instruction, its fields, address+4, valid flag
//   stall                 decode not ready; held instruction not consumed
//   redirect/selpctype/regaddr  PC-select decision applied on consumption
//   addrerr               sticky misaligned register-target flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imemaddr,
  output logic        imemreq,
  input  logic        imemack,
  input  logic [31:0] imemdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  fn,
  output logic [31:0] pc4,
  output logic        valid,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  selpctype,
  input  logic [31:0] regaddr,
  output logic        addrerr
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc4;
  logic         r_valid;
  logic         r_req;
  logic         r_addrerr;

  logic [31:0]  w_next_pc;
  logic         w_misalign;

  pc_next_calc u_pc_next_calc (
    .pc4       (r_pc4),
    .instr     (r_instr),
    .selpctype (selpctype),
    .redirect  (redirect),
    .regaddr   (regaddr),
    .nextpc    (w_next_pc),
    .misalign  (w_misalign)
  );

  // imemreq and valid are kept as registers set on the transition edge so
  // they line up with the state they describe without combinational decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_RST;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_pc4     <= '0;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_addrerr <= 1'b0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
        end
        ST_FETCH: begin
          if (imemack) begin
            r_instr <= imemdata;
            r_pc4   <= r_pc + 32'd4;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
            if (w_misalign) begin
              r_addrerr <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_RST;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imemaddr = r_pc;
  assign imemreq  = r_req;
  assign instr    = r_instr;
  assign op       = r_instr[OP_MSB:OP_LSB];
  assign fn       = r_instr[FN_MSB:FN_LSB];
  assign pc4      = r_pc4;
  assign valid    = r_valid;
  assign addrerr  = r_addrerr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan steps plus randomized transactions,
// checked against a transaction-level PC model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_w;
  logic        imemack, imemack_w;
  logic [31:0] imemdata;
  logic        stall, redirect;
  logic [1:0]  selpctype;
  logic [31:0] regaddr;

  logic [31:0] imemaddr, instr, pc4;
  logic [5:0]  op, fn;
  logic        imemreq, valid, addrerr;

  logic [31:0] imemaddr_w, instr_w, pc4_w;
  logic [5:0]  op_w, fn_w;
  logic        imemreq_w, valid_w, addrerr_w;

  fetch_unit dut (
    .clock(clk), .reset(reset), .imemaddr(imemaddr), .imemreq(imemreq),
    .imemack(imemack), .imemdata(imemdata), .instr(instr), .op(op), .fn(fn),
    .pc4(pc4), .valid(valid), .stall(stall), .redirect(redirect),
    .selpctype(selpctype), .regaddr(regaddr), .addrerr(addrerr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clock(clk), .reset(reset_w), .imemaddr(imemaddr_w), .imemreq(imemreq_w),
    .imemack(imemack_w), .imemdata(imemdata), .instr(instr_w), .op(op_w), .fn(fn_w),
    .pc4(pc4_w), .valid(valid_w), .stall(stall), .redirect(redirect),
    .selpctype(selpctype), .regaddr(regaddr), .addrerr(addrerr_w)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: address of the instruction being fetched/held, its word,
  // and the sticky error flag.
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_addrerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                           input logic redir, input logic [1:0] sel,
                                           input logic [31:0] ra, output logic mis);
    logic [31:0] seq;
    logic [15:0] imm16;
    int          off;
    seq = pc + 32'd4;
    mis = 1'b0;
    if (!redir || sel == 2'd0) return seq;
    if (sel == 2'd1) begin
      imm16 = word[15:0];
      off   = int'($signed(imm16));
      return seq + 32'(off * 4);
    end
    if (sel == 2'd2) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    mis = (ra % 4) != 0;
    return ra & ~32'h3;
  endfunction

  // Entered at a negedge while FETCH is active; leaves at the negedge where
  // the instruction is held.
  task automatic do_fetch(input logic [31:0] data, input int unsigned waits);
    for (int unsigned i = 0; i <= waits; i++) begin
      chk("fetch_req", 32'(imemreq), 32'd1);
      chk("fetch_addr", imemaddr, exp_pc);
      chk("fetch_valid", 32'(valid), 32'd0);
      imemack  = (i == waits);
      imemdata = (i == waits) ? data : $urandom;
      @(negedge clk);
    end
    imemack   = 1'b0;
    exp_instr = data;
    chk("hold_valid", 32'(valid), 32'd1);
    chk("hold_req", 32'(imemreq), 32'd0);
    chk("hold_instr", instr, exp_instr);
    chk("hold_op", 32'(op), exp_instr >> 26);
    chk("hold_fn", 32'(fn), exp_instr & 32'h3F);
    chk("hold_pc4", pc4, exp_pc + 32'd4);
    chk("hold_addrerr", 32'(addrerr), 32'(exp_addrerr));
  endtask

  // Stalls with random (ignored) redirect inputs, then consumes.
  task automatic do_hold(input int unsigned stalls, input logic redir,
                         input logic [1:0] sel, input logic [31:0] ra);
    logic mis;
    for (int unsigned i = 0; i < stalls; i++) begin
      stall     = 1'b1;
      redirect  = 1'($urandom);
      selpctype = 2'($urandom);
      regaddr   = $urandom;
      @(negedge clk);
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_req", 32'(imemreq), 32'd0);
      chk("stall_instr", instr, exp_instr);
      chk("stall_pc4", pc4, exp_pc + 32'd4);
      chk("stall_addrerr", 32'(addrerr), 32'(exp_addrerr));
    end
    stall     = 1'b0;
    redirect  = redir;
    selpctype = sel;
    regaddr   = ra;
    exp_pc = ref_next(exp_pc, exp_instr, redir, sel, ra, mis);
    if (mis) exp_addrerr = 1'b1;
    @(negedge clk);
    redirect  = 1'($urandom);
    selpctype = 2'($urandom);
    regaddr   = $urandom;
    chk("next_valid", 32'(valid), 32'd0);
    chk("next_req", 32'(imemreq), 32'd1);
    chk("next_addr", imemaddr, exp_pc);
    chk("next_addrerr", 32'(addrerr), 32'(exp_addrerr));
  endtask

  initial begin
    reset = 1'b1; reset_w = 1'b1; imemack = 1'b0; imemack_w = 1'b0;
    imemdata = '0; stall = 1'b0; redirect = 1'b0; selpctype = 2'd0; regaddr = '0;
    repeat (2) @(negedge clk);

    chk("rst_req", 32'(imemreq), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc4", pc4, 32'd0);
    chk("rst_addrerr", 32'(addrerr), 32'd0);
    chk("rst_addr", imemaddr, 32'd0);
    chk("rst_opfn", {20'd0, op, fn}, 32'd0);

    reset = 1'b0; exp_pc = 32'd0; exp_addrerr = 1'b0;
    @(negedge clk);

    // Sequential zero-wait fetch: 0, 4, 8.
    for (int k = 0; k < 3; k++) begin
      do_fetch(32'h0000_0020, 0);
      do_hold(0, 1'b0, 2'd0, 32'd0);
    end

    // Wait states then a long stall with redirect noise.
    do_fetch(32'h1234_5678, 3);
    do_hold(5, 1'b0, 2'd3, 32'h0000_0100);

    // Branch back to itself at 0x100 (reach it via an aligned register jump).
    do_fetch(32'h0, 0);
    do_hold(0, 1'b1, 2'd3, 32'h0000_0100);
    chk("br_setup", imemaddr, 32'h0000_0100);
    do_fetch(32'h1000_FFFF, 0);
    do_hold(0, 1'b1, 2'd1, 32'd0);
    chk("br_target", imemaddr, 32'h0000_0100);

    // Jump from 0x1000_0000.
    do_fetch(32'h0, 1);
    do_hold(0, 1'b1, 2'd3, 32'h1000_0000);
    do_fetch(32'h0800_0040, 0);
    do_hold(1, 1'b1, 2'd2, 32'd0);
    chk("jmp_target", imemaddr, 32'h1000_0100);

    // Misaligned register jump sets sticky addrerr.
    do_fetch(32'hABCD_0000, 0);
    do_hold(0, 1'b1, 2'd3, 32'h0000_2003);
    chk("reg_target", imemaddr, 32'h0000_2000);
    chk("reg_addrerr", 32'(addrerr), 32'd1);

    // Randomized transactions.
    for (int k = 0; k < 24; k++) begin
      do_fetch($urandom, $urandom_range(0, 2));
      do_hold($urandom_range(0, 2), 1'($urandom), 2'($urandom), $urandom);
    end

    // Reset mid-FETCH with an ack that must be ignored.
    reset = 1'b1; imemack = 1'b1; imemdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("midrst_req", 32'(imemreq), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_addrerr", 32'(addrerr), 32'd0);
    chk("midrst_addr", imemaddr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    imemack = 1'b0;
    chk("late_ack_req", 32'(imemreq), 32'd1);
    chk("late_ack_valid", 32'(valid), 32'd0);
    chk("late_ack_instr", instr, 32'd0);
    exp_pc = 32'd0; exp_addrerr = 1'b0;
    do_fetch(32'h0000_0020, 1);
    do_hold(0, 1'b0, 2'd0, 32'd0);

    // PC wrap with RESET_PC = 0xFFFF_FFFC.
    reset_w = 1'b0;
    @(negedge clk);
    chk("wrap_req", 32'(imemreq_w), 32'd1);
    chk("wrap_addr0", imemaddr_w, 32'hFFFF_FFFC);
    imemack_w = 1'b1; imemdata = 32'h0000_0020;
    @(negedge clk);
    imemack_w = 1'b0; stall = 1'b0; redirect = 1'b0;
    chk("wrap_valid", 32'(valid_w), 32'd1);
    chk("wrap_pc4", pc4_w, 32'd0);
    @(negedge clk);
    chk("wrap_req2", 32'(imemreq_w), 32'd1);
    chk("wrap_addr1", imemaddr_w, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
